// File: rtl/norm_seq_pkg.sv
// Shared definitions for the normalization sequencer.
// Covers the FSM encoding, the datapath width, the per-step shift amounts and the mode codes.
package norm_seq_pkg;

  localparam int unsigned WIDTH = 16;

  localparam logic [3:0] STEP_8 = 4'd8;
  localparam logic [3:0] STEP_4 = 4'd4;
  localparam logic [3:0] STEP_2 = 4'd2;
  localparam logic [3:0] STEP_1 = 4'd1;

  localparam logic MODE_LZ   = 1'b0;
  localparam logic MODE_SIGN = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S8   = 3'd1,
    ST_S4   = 3'd2,
    ST_S2   = 3'd3,
    ST_S1   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/norm_seq_step.sv
// Combinational test-and-shift for a single binary-search step.
// Each shift is a fixed constant, so no element shifts by more than one step amount.
module norm_step
  import norm_seq_pkg::*;
(
  input  logic [WIDTH-1:0] w,
  input  logic [3:0]       k,
  input  logic             mode,
  output logic [WIDTH-1:0] w_next,
  output logic             hit
);

  logic             lz_hit_s;
  logic             sign_hit_s;
  logic [WIDTH-1:0] shifted_s;

  // Per-step tests: leading k bits zero, or leading k+1 bits all equal.
  always_comb begin
    lz_hit_s   = 1'b0;
    sign_hit_s = 1'b0;
    shifted_s  = w;
    case (k)
      STEP_8: begin
        lz_hit_s   = (w[15:8] == 8'h00);
        sign_hit_s = (w[15:7] == 9'h000) || (w[15:7] == 9'h1FF);
        shifted_s  = {w[7:0], 8'h00};
      end
      STEP_4: begin
        lz_hit_s   = (w[15:12] == 4'h0);
        sign_hit_s = (w[15:11] == 5'h00) || (w[15:11] == 5'h1F);
        shifted_s  = {w[11:0], 4'h0};
      end
      STEP_2: begin
        lz_hit_s   = (w[15:14] == 2'b00);
        sign_hit_s = (w[15:13] == 3'b000) || (w[15:13] == 3'b111);
        shifted_s  = {w[13:0], 2'b00};
      end
      STEP_1: begin
        lz_hit_s   = (w[15] == 1'b0);
        sign_hit_s = (w[15:14] == 2'b00) || (w[15:14] == 2'b11);
        shifted_s  = {w[14:0], 1'b0};
      end
      default: begin
        lz_hit_s   = 1'b0;
        sign_hit_s = 1'b0;
        shifted_s  = w;
      end
    endcase
  end

  // Mode selects which test applies; a miss leaves the operand untouched.
  always_comb begin
    hit    = 1'b0;
    w_next = w;
    case (mode)
      MODE_LZ:   hit = lz_hit_s;
      MODE_SIGN: hit = sign_hit_s;
      default:   hit = 1'b0;
    endcase
    if (hit) begin
      w_next = shifted_s;
    end else begin
      w_next = w;
    end
  end

endmodule

// File: rtl/norm_seq.sv
// Fixed-latency normalizer: four binary-search steps (8/4/2/1) find the
// leading-zero or redundant-sign-bit count of a 16-bit operand.
module norm_seq
  import norm_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Norm_In,
  input  logic             Mode,
  output logic [WIDTH-1:0] Norm_Out,
  output logic [3:0]       Norm_Val,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] w_r;
  logic [3:0]       c_r;
  logic             mode_r;
  logic             zero_r;
  logic             busy_r;
  logic             done_r;
  logic [3:0]       k_s;
  logic             accept_s;
  logic [WIDTH-1:0] w_next_s;
  logic             hit_s;

  // Next-state logic; Start only matters in IDLE and DONE.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          state_s  = ST_S8;
          accept_s = 1'b1;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_S8:   state_s = ST_S4;
      ST_S4:   state_s = ST_S2;
      ST_S2:   state_s = ST_S1;
      ST_S1:   state_s = ST_DONE;
      ST_DONE: begin
        if (Start) begin
          state_s  = ST_S8;
          accept_s = 1'b1;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Step amount for the single shared step unit.
  always_comb begin
    k_s = 4'd0;
    case (state_r)
      ST_S8:   k_s = STEP_8;
      ST_S4:   k_s = STEP_4;
      ST_S2:   k_s = STEP_2;
      ST_S1:   k_s = STEP_1;
      default: k_s = 4'd0;
    endcase
  end

  norm_step u_step (
    .w      (w_r),
    .k      (k_s),
    .mode   (mode_r),
    .w_next (w_next_s),
    .hit    (hit_s)
  );

  // State register with Busy/Done registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_S8) || (state_s == ST_S4) ||
                 (state_s == ST_S2) || (state_s == ST_S1);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Operand capture and step accumulation; results hold outside the steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_r    <= 16'h0000;
      c_r    <= 4'd0;
      mode_r <= MODE_LZ;
      zero_r <= 1'b0;
    end else if (accept_s) begin
      w_r    <= Norm_In;
      c_r    <= 4'd0;
      mode_r <= Mode;
      zero_r <= (Norm_In == 16'h0000);
    end else if ((k_s != 4'd0) && hit_s) begin
      w_r    <= w_next_s;
      c_r    <= c_r + k_s;
    end else begin
      w_r    <= w_r;
      c_r    <= c_r;
    end
  end

  assign Norm_Out = w_r;
  assign Norm_Val = c_r;
  assign Zero     = zero_r;
  assign Busy     = busy_r;
  assign Done     = done_r;

endmodule

// File: tb/tb_norm_seq.sv
// Scoreboard bench for norm_seq: stimulus pushes expected results, a monitor
// pops and compares them on every Done pulse, including latency and shift invariants.
module tb_norm_seq;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic [15:0] Norm_In;
  logic        Mode;
  logic [15:0] Norm_Out;
  logic [3:0]  Norm_Val;
  logic        Zero;
  logic        Busy;
  logic        Done;

  int checks;
  int errors;
  int cyc;

  typedef struct {
    logic [15:0] din;
    logic        mode;
    logic [15:0] out;
    logic [3:0]  val;
    logic        zero;
    int          due;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [15:0] din;
    logic        mode;
    logic [15:0] out;
    logic [3:0]  val;
    logic        zero;
  } vec_t;

  vec_t vecs[13];

  norm_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Start    (Start),
    .Norm_In  (Norm_In),
    .Mode     (Mode),
    .Norm_Out (Norm_Out),
    .Norm_Val (Norm_Val),
    .Zero     (Zero),
    .Busy     (Busy),
    .Done     (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference normalizer: bitwise scan, capped at 15.
  task automatic model(input logic [15:0] d, input logic m,
                       output logic [15:0] o, output logic [3:0] v);
    int n;
    n = 0;
    if (m == 1'b0) begin
      while (n < 15 && d[15-n] == 1'b0) n++;
    end else begin
      while (n < 15 && d[14-n] == d[15]) n++;
    end
    v = n[3:0];
    o = d << n;
  endtask

  // Called at a negedge; acceptance happens on the following posedge.
  task automatic issue(input logic [15:0] d, input logic m, input logic [15:0] eo,
                       input logic [3:0] ev, input logic ez, input bit push);
    exp_t e;
    Start   = 1'b1;
    Norm_In = d;
    Mode    = m;
    if (push) begin
      e.din  = d;
      e.mode = m;
      e.out  = eo;
      e.val  = ev;
      e.zero = ez;
      e.due  = cyc + 5;
      sb.push_back(e);
    end
    @(negedge clk);
    Start   = 1'b0;
    Norm_In = ~d;
    Mode    = ~m;
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] sh;
    if (rst_n && Done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=1 at cycle %0d expected no result", cyc);
      end else begin
        e = sb.pop_front();
        check("norm_out", 32'(Norm_Out), 32'(e.out));
        check("norm_val", 32'(Norm_Val), 32'(e.val));
        check("zero", 32'(Zero), 32'(e.zero));
        check("latency", cyc, e.due);
        if (e.mode == 1'b0) begin
          sh = e.din << Norm_Val;
          check("inv_sll", 32'(sh), 32'(Norm_Out));
        end else begin
          sh = $signed(Norm_Out) >>> Norm_Val;
          check("inv_sra", 32'(sh), 32'(e.din));
        end
      end
    end
  end

  initial begin
    logic [15:0] d;
    logic [15:0] eo;
    logic [3:0]  ev;
    logic        m;
    int          guard;

    vecs[0]  = '{16'h0010, 1'b0, 16'h8000, 4'd11, 1'b0};
    vecs[1]  = '{16'hFFF0, 1'b1, 16'h8000, 4'd11, 1'b0};
    vecs[2]  = '{16'h0001, 1'b1, 16'h4000, 4'd14, 1'b0};
    vecs[3]  = '{16'h0000, 1'b0, 16'h0000, 4'd15, 1'b1};
    vecs[4]  = '{16'hFFFF, 1'b1, 16'h8000, 4'd15, 1'b0};
    vecs[5]  = '{16'h0000, 1'b1, 16'h0000, 4'd15, 1'b1};
    vecs[6]  = '{16'h8000, 1'b0, 16'h8000, 4'd0,  1'b0};
    vecs[7]  = '{16'h0001, 1'b0, 16'h8000, 4'd15, 1'b0};
    vecs[8]  = '{16'h00FF, 1'b0, 16'hFF00, 4'd8,  1'b0};
    vecs[9]  = '{16'hFF80, 1'b1, 16'h8000, 4'd8,  1'b0};
    vecs[10] = '{16'h0080, 1'b1, 16'h4000, 4'd7,  1'b0};
    vecs[11] = '{16'h7FFF, 1'b1, 16'h7FFF, 4'd0,  1'b0};
    vecs[12] = '{16'hC000, 1'b1, 16'h8000, 4'd1,  1'b0};

    checks  = 0;
    errors  = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    Start   = 1'b0;
    Norm_In = 16'h0000;
    Mode    = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_norm_out", 32'(Norm_Out), 32'h0);
    check("rst_norm_val", 32'(Norm_Val), 32'h0);
    check("rst_zero", 32'(Zero), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_done", 32'(Done), 32'h0);

    // First Start right at reset release; then directed vectors with idle gaps.
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].din, vecs[i].mode, vecs[i].out, vecs[i].val, vecs[i].zero, 1'b1);
      repeat (5) @(negedge clk);
    end

    // Start pulsed during S4 with a different operand must be ignored.
    issue(16'h0010, 1'b0, 16'h8000, 4'd11, 1'b0, 1'b1);
    @(negedge clk);
    Start   = 1'b1;
    Norm_In = 16'h1234;
    Mode    = 1'b1;
    @(negedge clk);
    Start   = 1'b0;
    check("busy_s2", 32'(Busy), 32'h1);
    @(negedge clk);
    check("busy_s1", 32'(Busy), 32'h1);
    @(negedge clk);
    check("busy_in_done", 32'(Busy), 32'h0);
    repeat (2) @(negedge clk);

    // Asynchronous reset in S2, then a normal operation.
    issue(16'h0010, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_norm_out", 32'(Norm_Out), 32'h0);
    check("arst_norm_val", 32'(Norm_Val), 32'h0);
    check("arst_busy", 32'(Busy), 32'h0);
    check("arst_done", 32'(Done), 32'h0);
    check("arst_zero", 32'(Zero), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h00FF, 1'b0, 16'hFF00, 4'd8, 1'b0, 1'b1);
    repeat (5) @(negedge clk);

    // Back-to-back random operations with Start held high and inputs scrambled mid-flight.
    Start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      d = 16'($urandom);
      if (i == 4) d = 16'h0000;
      if (i == 5) d = 16'hFFFF;
      m = i[0];
      model(d, m, eo, ev);
      Norm_In = d;
      Mode    = m;
      e.din  = d;
      e.mode = m;
      e.out  = eo;
      e.val  = ev;
      e.zero = (d == 16'h0000);
      e.due  = cyc + 5;
      sb.push_back(e);
      @(negedge clk);
      Norm_In = 16'($urandom);
      Mode    = ~m;
      repeat (4) @(negedge clk);
    end
    Start = 1'b0;

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
